// File: rtl/conv3x3_pipe_mc.sv
// -----------------------------------------------------------------------------
// conv3x3_pipe_mc
// Pipelined 3x3 multi-channel convolution engine with runtime-loadable weights.
// One 9-pixel window is accepted per cycle over a valid/ready handshake. The
// packed per-channel sums appear three registered stages later, and the engine
// supports full backpressure.
//
// Optional feature macro: CONV3X3_SAT_EN
//   defined   -> unsigned saturation of the channel sum to ACC_W bits
//   undefined -> modulo truncation of the channel sum to ACC_W bits
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   wgt_wr_en/ch/tap/data  weight write port (tap k multiplies pixel k)
//   in_valid, in_ready     input window handshake
//   pixels_in              pixel k at [k*PIX_W +: PIX_W]
//   out_valid, out_ready   output handshake
//   result_out             channel c at [c*ACC_W +: ACC_W]
// -----------------------------------------------------------------------------
module conv3x3_pipe_mc #(
  parameter int PIX_W  = 8,
  parameter int WGT_W  = 8,
  parameter int NUM_CH = 8,
  parameter int ACC_W  = 16,
  localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wgt_wr_en,
  input  logic [CHW-1:0]          wgt_wr_ch,
  input  logic [3:0]              wgt_wr_tap,
  input  logic [WGT_W-1:0]        wgt_wr_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [9*PIX_W-1:0]      pixels_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*ACC_W-1:0] result_out
);

  localparam int PROD_W = PIX_W + WGT_W;
  localparam int ROW_W  = PROD_W + 2;
  localparam int SUM_W  = PIX_W + WGT_W + 4;

  logic [WGT_W-1:0]        weight_q [NUM_CH][9];
  logic [PROD_W-1:0]       prod_q   [NUM_CH][9];
  logic [PROD_W-1:0]       prod_d   [NUM_CH][9];
  logic [ROW_W-1:0]        rowSum_q [NUM_CH][3];
  logic [ROW_W-1:0]        rowSum_d [NUM_CH][3];
  logic [SUM_W-1:0]        chanSum  [NUM_CH];
  logic [NUM_CH*ACC_W-1:0] result_q;
  logic [NUM_CH*ACC_W-1:0] result_d;
  logic                    s1Valid_q;
  logic                    s2Valid_q;
  logic                    outValid_q;
  logic                    advance;

  // Squeeze a full-precision channel sum into the output width. When ACC_W is
  // at least SUM_W both branches reduce to plain zero extension.
  function automatic logic [ACC_W-1:0] fitSum(input logic [SUM_W-1:0] s);
`ifdef CONV3X3_SAT_EN
    logic [ACC_W+SUM_W-1:0] wide;
    wide = {{ACC_W{1'b0}}, s};
    if (|wide[ACC_W+SUM_W-1:ACC_W]) fitSum = '1;
    else                            fitSum = wide[ACC_W-1:0];
`else
    fitSum = ACC_W'(s);
`endif
  endfunction

  // The whole pipeline moves as one; it only freezes while a result is
  // waiting for the consumer.
  assign advance    = !outValid_q || out_ready;
  assign in_ready   = advance;
  assign out_valid  = outValid_q;
  assign result_out = result_q;

  // Next-state datapath for the three stages.
  always_comb begin
    result_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < 9; k++) begin
        prod_d[c][k] = PROD_W'(pixels_in[k*PIX_W +: PIX_W]) * PROD_W'(weight_q[c][k]);
      end
      for (int r = 0; r < 3; r++) begin
        rowSum_d[c][r] = ROW_W'(prod_q[c][3*r]) + ROW_W'(prod_q[c][3*r+1])
                       + ROW_W'(prod_q[c][3*r+2]);
      end
      chanSum[c] = SUM_W'(rowSum_q[c][0]) + SUM_W'(rowSum_q[c][1]) + SUM_W'(rowSum_q[c][2]);
      result_d[c*ACC_W +: ACC_W] = fitSum(chanSum[c]);
    end
  end

  // Pipeline registers; bubbles travel with valid=0 when nothing is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s2Valid_q  <= 1'b0;
      outValid_q <= 1'b0;
      result_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < 9; k++) prod_q[c][k] <= '0;
        for (int r = 0; r < 3; r++) rowSum_q[c][r] <= '0;
      end
    end else if (advance) begin
      s1Valid_q  <= in_valid;
      s2Valid_q  <= s1Valid_q;
      outValid_q <= s2Valid_q;
      result_q   <= result_d;
      prod_q     <= prod_d;
      rowSum_q   <= rowSum_d;
    end
  end

  // Weight store. Products sample the old weight on the write edge, and data
  // already past S1 no longer depends on the weights. Out-of-range channel or
  // tap simply matches no entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < 9; k++) weight_q[c][k] <= WGT_W'(c + k + 2);
      end
    end else if (wgt_wr_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < 9; k++) begin
          if (wgt_wr_ch == CHW'(c) && wgt_wr_tap == 4'(k)) weight_q[c][k] <= wgt_wr_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_pipe_mc.sv
// -----------------------------------------------------------------------------
// tb_conv3x3_pipe_mc
// Self-checking bench for conv3x3_pipe_mc. A reference model keeps its own
// weight table and a queue of accepted windows, each carrying its expected
// result and the number of pipeline moves it has made; a window is due at the
// output once it has moved three times.
// -----------------------------------------------------------------------------
module tb_conv3x3_pipe_mc;

  localparam int PIX_W  = 8;
  localparam int WGT_W  = 8;
  localparam int NUM_CH = 8;
  localparam int ACC_W  = 16;
  localparam int CHW    = 3;
  localparam int RES_W  = NUM_CH * ACC_W;

  logic             clk;
  logic             rst;
  logic             wgt_wr_en;
  logic [CHW-1:0]   wgt_wr_ch;
  logic [3:0]       wgt_wr_tap;
  logic [WGT_W-1:0] wgt_wr_data;
  logic             in_valid;
  logic             in_ready;
  logic [9*PIX_W-1:0] pixels_in;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] result_out;

  typedef struct {
    logic [RES_W-1:0] data;
    int               age;
  } entry_t;

  entry_t inFlight[$];
  int     mw [NUM_CH][9];
  int     total = 0;
  int     bad   = 0;

  conv3x3_pipe_mc #(
    .PIX_W(PIX_W), .WGT_W(WGT_W), .NUM_CH(NUM_CH), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst),
    .wgt_wr_en(wgt_wr_en), .wgt_wr_ch(wgt_wr_ch), .wgt_wr_tap(wgt_wr_tap),
    .wgt_wr_data(wgt_wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .pixels_in(pixels_in),
    .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [RES_W-1:0] obs,
                             input logic [RES_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ACC_W-1:0] fit(input longint s);
`ifdef CONV3X3_SAT_EN
    return (s > 65535) ? 16'hFFFF : 16'(s);
`else
    return 16'(s % 65536);
`endif
  endfunction

  function automatic logic [RES_W-1:0] modelResult(input logic [9*PIX_W-1:0] pix);
    logic [RES_W-1:0] r;
    longint s;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      s = 0;
      for (int k = 0; k < 9; k++) s += longint'(pix[k*PIX_W +: PIX_W]) * longint'(mw[c][k]);
      r[c*ACC_W +: ACC_W] = fit(s);
    end
    return r;
  endfunction

  function automatic logic [9*PIX_W-1:0] allPix(input int v);
    logic [9*PIX_W-1:0] p;
    for (int k = 0; k < 9; k++) p[k*PIX_W +: PIX_W] = 8'(v);
    return p;
  endfunction

  task automatic resetModel();
    inFlight.delete();
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < 9; k++) mw[c][k] = (c + k + 2) % 256;
  endtask

  // One clock cycle: drive inputs just after a falling edge, check the DUT
  // against the model, advance the model, then move to the next falling edge.
  task automatic applyStimulus(input logic v, input logic [9*PIX_W-1:0] pix,
                               input logic ordy, input logic wen, input int wch,
                               input int wtap, input int wdat);
    logic expOV;
    logic adv;
    entry_t e;
    in_valid    = v;
    pixels_in   = pix;
    out_ready   = ordy;
    wgt_wr_en   = wen;
    wgt_wr_ch   = CHW'(wch);
    wgt_wr_tap  = 4'(wtap);
    wgt_wr_data = 8'(wdat);
    #1;
    expOV = (inFlight.size() > 0) && (inFlight[0].age == 3);
    adv   = !expOV || ordy;
    checkOutput("out_valid", RES_W'(out_valid), RES_W'(expOV));
    checkOutput("in_ready", RES_W'(in_ready), RES_W'(adv));
    if (expOV) checkOutput("result_out", result_out, inFlight[0].data);
    if (adv) begin
      if (expOV) void'(inFlight.pop_front());
      if (v) begin
        e.data = modelResult(pix);
        e.age  = 0;
        inFlight.push_back(e);
      end
      foreach (inFlight[i]) inFlight[i].age = inFlight[i].age + 1;
    end
    if (wen && wch < NUM_CH && wtap <= 8) mw[wch][wtap] = wdat;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, ordy, 1'b0, 0, 0, 0);
  endtask

  // Present one window, then hold the consumer off so the result sits at the
  // output for direct inspection.
  task automatic windowAndHold(input logic [9*PIX_W-1:0] pix);
    applyStimulus(1'b1, pix, 1'b1, 1'b0, 0, 0, 0);
    idle(2, 1'b0);
    checkOutput("held_valid", RES_W'(out_valid), RES_W'(1'b1));
  endtask

  initial begin
    logic [9*PIX_W-1:0] rp;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pixels_in = '0;
    wgt_wr_en = 1'b0; wgt_wr_ch = '0; wgt_wr_tap = '0; wgt_wr_data = '0;
    resetModel();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", RES_W'(out_valid), '0);
    checkOutput("reset_result", result_out, '0);
    checkOutput("reset_in_ready", RES_W'(in_ready), RES_W'(1'b1));
    rst = 1'b0;

    // Default weights, all pixels one.
    windowAndHold(allPix(1));
    checkOutput("t1_ch0", RES_W'(result_out[0*ACC_W +: ACC_W]), RES_W'(54));
    checkOutput("t1_ch7", RES_W'(result_out[7*ACC_W +: ACC_W]), RES_W'(117));
    checkOutput("t1_ch3", RES_W'(result_out[3*ACC_W +: ACC_W]), RES_W'(81));
    idle(2, 1'b1);

    // Back-to-back stream.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, allPix(i + 1), 1'b1, 1'b0, 0, 0, 0);
    idle(4, 1'b1);

    // Consumer stalls for six cycles while five windows are offered.
    for (int i = 0; i < 6; i++) begin
      rp = 72'({$urandom, $urandom, $urandom});
      applyStimulus(i < 5, rp, 1'b0, 1'b0, 0, 0, 0);
    end
    idle(8, 1'b1);
    checkOutput("t3_drained", RES_W'(inFlight.size()), '0);

    // Channel 0 weights to full scale, pixels full scale.
    for (int k = 0; k < 9; k++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 0, k, 255);
    windowAndHold(allPix(255));
`ifdef CONV3X3_SAT_EN
    checkOutput("t4_ch0", RES_W'(result_out[0 +: ACC_W]), RES_W'(65535));
`else
    checkOutput("t4_ch0", RES_W'(result_out[0 +: ACC_W]), RES_W'(60937));
`endif
    checkOutput("t4_ch1", RES_W'(result_out[ACC_W +: ACC_W]),
                RES_W'((3+4+5+6+7+8+9+10+11) * 255));
    idle(2, 1'b1);

    // Weight write coinciding with an accepted window, then an invalid tap.
    applyStimulus(1'b1, allPix(3), 1'b1, 1'b1, 2, 4, 0);
    applyStimulus(1'b1, allPix(3), 1'b1, 1'b1, 2, 9, 99);
    applyStimulus(1'b1, allPix(5), 1'b1, 1'b0, 0, 0, 0);
    idle(4, 1'b1);

    // Randomised traffic with occasional (sometimes invalid) weight writes.
    for (int i = 0; i < 300; i++) begin
      rp = 72'({$urandom, $urandom, $urandom});
      applyStimulus(($urandom % 4) != 0, rp, ($urandom % 3) != 0, ($urandom % 8) == 0,
                    int'($urandom % 8), int'($urandom % 11), int'($urandom % 256));
    end
    idle(5, 1'b1);
    checkOutput("rand_drained", RES_W'(inFlight.size()), '0);

    // Reset with windows in flight.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, allPix(7 + i), 1'b1, 1'b1, 1, i, 200);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_out_valid", RES_W'(out_valid), '0);
    checkOutput("t6_result", result_out, '0);
    resetModel();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(5, 1'b1);
    windowAndHold(allPix(1));
    checkOutput("t6_ch0", RES_W'(result_out[0 +: ACC_W]), RES_W'(54));
    checkOutput("t6_ch1", RES_W'(result_out[ACC_W +: ACC_W]), RES_W'(63));
    idle(3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
